// File: rtl/sort_register.sv
// One cell of a linear systolic insertion sorter holding a descending list.
// Define SORT_REG_SIGNED_EN for a two's-complement compare (default: unsigned).
module sort_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             GT_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] prev_data,
  output logic [WIDTH-1:0] data_out,
  output logic             GT
);

  // Smallest representable value, so an empty cell accepts any insertion.
  function automatic logic [WIDTH-1:0] min_value();
    logic [WIDTH-1:0] v;
    v = '0;
`ifdef SORT_REG_SIGNED_EN
    v[WIDTH-1] = 1'b1;
`endif
    return v;
  endfunction

  localparam logic [WIDTH-1:0] RESET_VAL = min_value();

  logic [WIDTH-1:0] stored_r;
  logic             gt_s;

  // Strict greater-than of the broadcast value against the stored value.
  always_comb begin
    gt_s = 1'b0;
`ifdef SORT_REG_SIGNED_EN
    if ($signed(data_in) > $signed(stored_r)) begin
      gt_s = 1'b1;
    end else begin
      gt_s = 1'b0;
    end
`else
    if (data_in > stored_r) begin
      gt_s = 1'b1;
    end else begin
      gt_s = 1'b0;
    end
`endif
  end

  // Hold, shift down from upstream, or capture the new value at the insertion point.
  always_ff @(posedge clk) begin
    if (rst) begin
      stored_r <= RESET_VAL;
    end else if (gt_s && GT_in) begin
      stored_r <= prev_data;
    end else if (gt_s) begin
      stored_r <= data_in;
    end else begin
      stored_r <= stored_r;
    end
  end

  assign data_out = stored_r;
  assign GT       = gt_s;

endmodule

// File: tb/tb_sort_register.sv
// Bench: a standalone cell checked against hand-computed vectors, and a
// four-cell chain checked every cycle against a sorted-list model.
module tb_sort_register;
  localparam int W = 8;
  localparam int N = 4;
`ifdef SORT_REG_SIGNED_EN
  localparam logic [W-1:0] RV = 8'h80;
`else
  localparam logic [W-1:0] RV = 8'h00;
`endif

  typedef logic [W-1:0] list_t [N];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         gt_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] cell_q;
  logic         cell_gt;
  logic [W-1:0] chain_q [N];
  logic         chain_gt [N];
  list_t        model;
  logic         chk_en = 1'b0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  sort_register #(.WIDTH(W)) u_cell (
    .clk(clk), .rst(rst), .GT_in(gt_in), .data_in(data_in),
    .prev_data(prev_data), .data_out(cell_q), .GT(cell_gt)
  );

  for (genvar g = 0; g < N; g++) begin : g_chain
    if (g == 0) begin : g_head
      sort_register #(.WIDTH(W)) u_c (
        .clk(clk), .rst(rst), .GT_in(1'b0), .data_in(data_in),
        .prev_data(8'h00), .data_out(chain_q[g]), .GT(chain_gt[g])
      );
    end else begin : g_body
      sort_register #(.WIDTH(W)) u_c (
        .clk(clk), .rst(rst), .GT_in(chain_gt[g-1]), .data_in(data_in),
        .prev_data(chain_q[g-1]), .data_out(chain_q[g]), .GT(chain_gt[g])
      );
    end
  end

  function automatic bit greater(logic [W-1:0] a, logic [W-1:0] b);
`ifdef SORT_REG_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Stable insert: the new value goes after every entry not smaller than it.
  function automatic list_t insert(list_t a, logic [W-1:0] x);
    list_t r;
    int pos = 0;
    for (int i = 0; i < N; i++) if (!greater(x, a[i])) pos++;
    for (int i = 0; i < N; i++) begin
      if (i < pos) r[i] = a[i];
      else if (i == pos) r[i] = x;
      else r[i] = a[i-1];
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference list follows every clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) model[i] <= RV;
    end else begin
      model <= insert(model, data_in);
    end
  end

  // Chain contents and compare flags against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("chain_q[%0d]", i), 32'(chain_q[i]), 32'(model[i]));
        if (!$isunknown(data_in))
          check($sformatf("chain_gt[%0d]", i), 32'(chain_gt[i]), 32'(greater(data_in, model[i])));
      end
    end
  end

  task automatic drive(logic r, logic [W-1:0] d, logic [W-1:0] p, logic g);
    @(posedge clk);
    #2;
    rst = r; data_in = d; prev_data = p; gt_in = g;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; data_in = 'x;
    repeat (5) @(posedge clk);
    #2;
    chk_en = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    mid();
    check("reset_q", 32'(cell_q), 32'(RV));
`ifndef SORT_REG_SIGNED_EN
    check("reset_gt", 32'(cell_gt), 32'd0);
    // Shift from upstream.
    drive(1'b0, 8'hAA, 8'h0A, 1'b1);
    mid(); check("shift_gt", 32'(cell_gt), 32'd1);
    drive(1'b0, 8'hAA, 8'h0A, 1'b1);
    mid(); check("shift_q1", 32'(cell_q), 32'h0A);
    drive(1'b0, 8'hAA, 8'h0A, 1'b1);
    mid(); check("shift_q2", 32'(cell_q), 32'h0A);
    // Insertion point.
    drive(1'b0, 8'h0B, 8'h11, 1'b0);
    mid(); check("ins_gt", 32'(cell_gt), 32'd1);
    drive(1'b0, 8'h0B, 8'h11, 1'b0);
    mid(); check("ins_q", 32'(cell_q), 32'h0B);
    check("ins_gt_drop", 32'(cell_gt), 32'd0);
    // Inconsistent GT_in with GT=0 holds.
    drive(1'b0, 8'h05, 8'h04, 1'b1);
    mid(); check("hold_gt", 32'(cell_gt), 32'd0);
    drive(1'b0, 8'h05, 8'h04, 1'b1);
    mid(); check("hold_q", 32'(cell_q), 32'h0B);
    // Equal value does not displace.
    drive(1'b0, 8'h0B, 8'h04, 1'b0);
    mid(); check("eq_gt", 32'(cell_gt), 32'd0);
    drive(1'b0, 8'h0B, 8'h04, 1'b0);
    mid(); check("eq_q", 32'(cell_q), 32'h0B);
    // Reset beats a simultaneous shift.
    drive(1'b1, 8'hF0, 8'h33, 1'b1);
    mid(); check("rst_mid_gt_pre", 32'(cell_gt), 32'd1);
    drive(1'b1, 8'hF0, 8'h33, 1'b1);
    mid(); check("rst_mid_q", 32'(cell_q), 32'h00);
    check("rst_mid_gt", 32'(cell_gt), 32'd1);
`endif
    // Chain fill from reset.
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h30, 8'h00, 1'b0);
    drive(1'b0, 8'h10, 8'h00, 1'b0);
    drive(1'b0, 8'h20, 8'h00, 1'b0);
    drive(1'b0, 8'h40, 8'h00, 1'b0);
    drive(1'b0, RV, 8'h00, 1'b0);
    mid();
    check("chain0", 32'(chain_q[0]), 32'h40);
    check("chain1", 32'(chain_q[1]), 32'h30);
    check("chain2", 32'(chain_q[2]), 32'h20);
    check("chain3", 32'(chain_q[3]), 32'h10);
    // Duplicate lands after its equal; tail drops off.
    drive(1'b0, 8'h20, 8'h00, 1'b0);
    drive(1'b0, RV, 8'h00, 1'b0);
    mid();
    check("dup2", 32'(chain_q[2]), 32'h20);
    check("dup3", 32'(chain_q[3]), 32'h20);
`ifndef SORT_REG_SIGNED_EN
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    mid();
    check("max0", 32'(chain_q[0]), 32'hFF);
    check("max3", 32'(chain_q[3]), 32'h20);
`else
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h80, 8'h00, 1'b0);
    drive(1'b0, 8'h7F, 8'h00, 1'b0);
    drive(1'b0, 8'h80, 8'h00, 1'b0);
    mid();
    check("sgn0", 32'(chain_q[0]), 32'h7F);
    check("sgn1", 32'(chain_q[1]), 32'h80);
`endif
    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
